// File: rtl/key_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// key_scan_ctrl
//   Synchronises and debounces KEY_NUM active-low mechanical push-buttons and
//   turns each one into clean, registered events for the LED/mode logic.
//
// Ports
//   sys_clk      in   system clock; all logic on the rising edge
//   sys_rst      in   asynchronous, active-high reset
//   key          in   [KEY_NUM] raw key pins, 0 = pressed, asynchronous
//   key_press    out  [KEY_NUM] one-cycle pulse per accepted press
//   key_release  out  [KEY_NUM] one-cycle pulse per accepted release
//   key_long     out  [KEY_NUM] one-cycle pulse when a held key reaches
//                               LONG_CYCLES cycles after its press
//   key_state    out  [KEY_NUM] debounced level, 1 = pressed
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept an edge (>= 2)
//   LONG_CYCLES      cycles accepted-down before key_long (> DEBOUNCE_CYCLES)
// -----------------------------------------------------------------------------
module key_scan_ctrl #(
  parameter int KEY_NUM         = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_state
);

  localparam int CNT_W = $clog2(LONG_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,  // released, waiting for a low sample
    FILT_DN = 3'd1,  // counting stable low samples
    DOWN    = 3'd2,  // accepted pressed, counting towards long press
    HOLD    = 3'd3,  // pressed; long press issued or no longer possible
    FILT_UP = 3'd4   // counting stable high samples
  } state_t;

  // Two-flop synchroniser. Flops reset to 1 (released) so a key held
  // through reset is re-debounced rather than seen as an instant press.
  logic [KEY_NUM-1:0] sync1_q;
  logic [KEY_NUM-1:0] sync2_q;
  logic [KEY_NUM-1:0] k_sync;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  assign k_sync = sync2_q;

  // One independent debounce/long-press FSM per key.
  generate
    for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_key
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             press_q, press_d;
      logic             release_q, release_d;
      logic             long_q, long_d;
      logic             level_q, level_d;

      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        level_d   = level_q;
        case (state_q)
          IDLE: begin
            if (!k_sync[gi]) begin
              state_d = FILT_DN;
              cnt_d   = CNT_W'(1);  // this low sample already counts
            end
          end
          FILT_DN: begin
            if (k_sync[gi]) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
              state_d = DOWN;
              cnt_d   = '0;
              press_d = 1'b1;
              level_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          DOWN: begin
            if (k_sync[gi]) begin
              state_d = FILT_UP;
              cnt_d   = CNT_W'(1);
            end else if (cnt_q == LONG_LAST) begin
              state_d = HOLD;
              cnt_d   = '0;
              long_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          HOLD: begin
            if (k_sync[gi]) begin
              state_d = FILT_UP;
              cnt_d   = CNT_W'(1);
            end
          end
          FILT_UP: begin
            // A release glitch returns to HOLD, never DOWN, so the long-press
            // timer is not restarted and key_long cannot fire twice.
            if (!k_sync[gi]) begin
              state_d = HOLD;
              cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
              state_d   = IDLE;
              cnt_d     = '0;
              release_d = 1'b1;
              level_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
          end
        endcase
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          long_q    <= 1'b0;
          level_q   <= 1'b0;
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          press_q   <= press_d;
          release_q <= release_d;
          long_q    <= long_d;
          level_q   <= level_d;
        end
      end

      assign key_press[gi]   = press_q;
      assign key_release[gi] = release_q;
      assign key_long[gi]    = long_q;
      assign key_state[gi]   = level_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_scan_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_key_scan_ctrl
//   Directed stimulus for key_scan_ctrl with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
//   The stimulus process pushes expected pulse events (edge count, pulse
//   vectors, debounced level) into a queue; the monitor pops one entry each
//   time the DUT shows a pulse and checks the level on every other sample.
// -----------------------------------------------------------------------------
module tb_key_scan_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] key     = 2'b11;
  logic [1:0] key_press, key_release, key_long, key_state;

  int  e      = 0;  // number of rising edges seen so far
  bit  done   = 1'b0;
  int  checks = 0;
  int  errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] state;
  } exp_t;

  exp_t sb_q[$];

  key_scan_ctrl #(
    .KEY_NUM        (2),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key        (key),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_state  (key_state)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) e <= e + 1;

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input int c, input logic [1:0] p, input logic [1:0] r,
                      input logic [1:0] l, input logic [1:0] st);
    exp_t it;
    it.cyc   = c;
    it.press = p;
    it.rel   = r;
    it.lng   = l;
    it.state = st;
    sb_q.push_back(it);
  endtask

  // Stimulus. A key changed at the negedge where e == s is first captured
  // by edge s; a press/release pulse is then visible once e == s + 6.
  initial begin : stimulus
    int s;
    int d;
    #200 sys_rst = 1'b0;

    // Clean press held long: press, one long pulse 16 edges later, release.
    step(1); s = e; key[0] = 1'b0;
    push(s + 6,  2'b01, 2'b00, 2'b00, 2'b01);
    push(s + 22, 2'b00, 2'b00, 2'b01, 2'b01);
    step(40); key[0] = 1'b1;
    push(s + 46, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Bounce then short press: glitch rejected, single press, no long.
    step(1); s = e; key[0] = 1'b0;
    step(2); key[0] = 1'b1;
    step(1); key[0] = 1'b0;
    push(s + 9, 2'b01, 2'b00, 2'b00, 2'b01);
    step(10); key[0] = 1'b1;
    push(s + 19, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Release glitch while in HOLD: no release, no second long.
    step(1); s = e; key[0] = 1'b0;
    push(s + 6,  2'b01, 2'b00, 2'b00, 2'b01);
    push(s + 22, 2'b00, 2'b00, 2'b01, 2'b01);
    step(30); key[0] = 1'b1;
    step(2);  key[0] = 1'b0;
    step(8);  key[0] = 1'b1;
    push(s + 46, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Release glitch while in DOWN: goes to HOLD, so key_long never fires.
    step(1); s = e; key[0] = 1'b0;
    push(s + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    step(8);  key[0] = 1'b1;
    step(1);  key[0] = 1'b0;
    step(11); key[0] = 1'b1;
    push(s + 26, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Simultaneous press, staggered releases.
    step(1); s = e; key = 2'b00;
    push(s + 6, 2'b11, 2'b00, 2'b00, 2'b11);
    step(10); key[1] = 1'b1;
    push(s + 16, 2'b00, 2'b10, 2'b00, 2'b01);
    step(2);  key[0] = 1'b1;
    push(s + 18, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    // Reset while held in DOWN: fresh press afterwards, no stale release.
    step(1); s = e; key[0] = 1'b0;
    push(s + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    step(10); sys_rst = 1'b1;
    step(3);  sys_rst = 1'b0; d = e;
    push(d + 6, 2'b01, 2'b00, 2'b00, 2'b01);
    step(12); key[0] = 1'b1;
    push(d + 18, 2'b00, 2'b01, 2'b00, 2'b00);
    step(10);

    done = 1'b1;
  end

  // Monitor: samples 5 ns after each rising clock edge and 5 ns after reset
  // rises, so asynchronous clearing is observed before the next clock edge.
  initial begin : monitor
    logic [1:0] exp_level;
    exp_t       it;
    exp_level = 2'b00;
    forever begin
      @(posedge sys_clk or posedge sys_rst);
      #5;
      if (done) break;
      if (e > 3000) begin
        errors++;
        $display("FAIL timeout e=%0d pending=%0d required=0", e, sb_q.size());
        break;
      end
      if (sys_rst) begin
        checks++;
        exp_level = 2'b00;
        if ({key_press, key_release, key_long, key_state} !== 8'h00) begin
          errors++;
          $display("FAIL reset_outputs got p=%b r=%b l=%b s=%b required all 0",
                   key_press, key_release, key_long, key_state);
        end
      end else if (|{key_press, key_release, key_long}) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_pulse e=%0d got p=%b r=%b l=%b required none",
                   e, key_press, key_release, key_long);
        end else begin
          it = sb_q.pop_front();
          $display("event e=%0d p=%b r=%b l=%b s=%b (expected e=%0d p=%b r=%b l=%b s=%b)",
                   e, key_press, key_release, key_long, key_state,
                   it.cyc, it.press, it.rel, it.lng, it.state);
          if (it.cyc != e ||
              {key_press, key_release, key_long, key_state} !==
              {it.press, it.rel, it.lng, it.state}) begin
            errors++;
            $display("FAIL pulse_event got e=%0d p=%b r=%b l=%b s=%b required e=%0d p=%b r=%b l=%b s=%b",
                     e, key_press, key_release, key_long, key_state,
                     it.cyc, it.press, it.rel, it.lng, it.state);
          end
          exp_level = it.state;
        end
      end else begin
        checks++;
        if (key_state !== exp_level) begin
          errors++;
          $display("FAIL key_state e=%0d got %b required %b", e, key_state, exp_level);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc <= e) begin
          checks++;
          errors++;
          it = sb_q.pop_front();
          $display("FAIL missed_pulse e=%0d got none required p=%b r=%b l=%b at e=%0d",
                   e, it.press, it.rel, it.lng, it.cyc);
          exp_level = it.state;
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got %0d pending required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
